// File: rtl/phase_ring_checker.sv
// phase_ring_checker: validates a one-hot 4-phase ring (code, order, dwell) and reports lock/health
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   ph_in     : one-hot phase bus from the divider
//   locked    : lock indicator
//   phase_idx : active phase index while locked, else 0
//   rot_cnt   : completed rotations while locked (wraps)
//   err       : one-clock error pulse
//   err_cnt   : error count, saturating at 255
module phase_ring_checker #(
    parameter int HOLD   = 1,
    parameter int LOCK_N = 4,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    ph_in,
    output logic          locked,
    output logic [1:0]    phase_idx,
    output logic [CW-1:0] rot_cnt,
    output logic          err,
    output logic [7:0]    err_cnt
);
    localparam int DW = $clog2(HOLD + 2);
    localparam int GW = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;

    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

    state_t        state;
    logic [3:0]    cur;
    logic [DW-1:0] dwell;
    logic [GW-1:0] good_cnt;

    logic       onehot, change, at_hold, good_step, stall, fault;
    logic [1:0] idx;
    logic [7:0] err_next;

    always_comb begin
        onehot    = $onehot(ph_in);
        change    = ph_in != cur;
        at_hold   = dwell == DW'(HOLD);
        good_step = change && onehot && ph_in == {cur[2:0], cur[3]} && at_hold;
        // a late change shows up here as an unchanged sample at the HOLD-th dwell
        stall     = !change && at_hold;
        fault     = !onehot || (change && !good_step) || stall;
        idx       = {ph_in[3] | ph_in[2], ph_in[3] | ph_in[1]};
        err_next  = (err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur       <= '0;
            dwell     <= '0;
            good_cnt  <= '0;
            locked    <= 1'b0;
            phase_idx <= '0;
            rot_cnt   <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            cur   <= ph_in;
            dwell <= change ? DW'(1) : (dwell == DW'(HOLD + 1)) ? dwell : dwell + DW'(1);
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (change && onehot) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                ACQ: begin
                    if (fault) begin
                        state   <= IDLE;
                        err     <= 1'b1;
                        err_cnt <= err_next;
                    end else if (good_step) begin
                        if (good_cnt == GW'(LOCK_N - 1)) begin
                            state     <= LOCK;
                            locked    <= 1'b1;
                            phase_idx <= idx;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                end
                LOCK: begin
                    if (fault) begin
                        state     <= IDLE;
                        locked    <= 1'b0;
                        phase_idx <= '0;
                        err       <= 1'b1;
                        err_cnt   <= err_next;
                    end else if (good_step) begin
                        phase_idx <= idx;
                        if (ph_in == 4'b0001)
                            rot_cnt <= rot_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phase_ring_checker.sv
// tb_phase_ring_checker: directed self-checking bench for phase_ring_checker (HOLD=2, LOCK_N=4, CW=8)
module tb_phase_ring_checker;
    logic       clk;
    logic       reset;
    logic [3:0] ph_in;
    logic       locked;
    logic [1:0] phase_idx;
    logic [7:0] rot_cnt;
    logic       err;
    logic [7:0] err_cnt;
    int errors = 0;
    int checks = 0;

    phase_ring_checker #(.HOLD(2), .LOCK_N(4), .CW(8)) dut (
        .clk(clk), .reset(reset), .ph_in(ph_in), .locked(locked),
        .phase_idx(phase_idx), .rot_cnt(rot_cnt), .err(err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [3:0] v);
        @(negedge clk);
        ph_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic hp(input logic [3:0] v);
        step(v);
        step(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        ph_in = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_idx", phase_idx, 0);
        chk("rst_rot", rot_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_errcnt", err_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        // clean lock
        step(4'b0001);
        chk("acq_locked", locked, 0);
        step(4'b0001);
        hp(4'b0010);
        hp(4'b0100);
        hp(4'b1000);
        chk("prelock_locked", locked, 0);
        chk("prelock_err", err, 0);
        step(4'b0001);
        chk("lock_locked", locked, 1);
        chk("lock_idx", phase_idx, 0);
        chk("lock_rot", rot_cnt, 0);
        step(4'b0001);
        hp(4'b0010);
        chk("idx1", phase_idx, 1);
        hp(4'b0100);
        chk("idx2", phase_idx, 2);
        hp(4'b1000);
        chk("idx3", phase_idx, 3);
        step(4'b0001);
        chk("idx0", phase_idx, 0);
        chk("rot1", rot_cnt, 1);
        step(4'b0001);
        chk("clean_err", err, 0);
        // stall on 0100
        hp(4'b0010);
        hp(4'b0100);
        chk("stall_pre_err", err, 0);
        chk("stall_pre_locked", locked, 1);
        step(4'b0100);
        chk("stall_err", err, 1);
        chk("stall_locked", locked, 0);
        chk("stall_errcnt", err_cnt, 1);
        chk("stall_rot", rot_cnt, 1);
        chk("stall_idx", phase_idx, 0);
        step(4'b0100);
        chk("stall_pulse", err, 0);
        // bad code
        hp(4'b1000);
        hp(4'b0001);
        hp(4'b0010);
        hp(4'b0100);
        step(4'b1000);
        chk("relock1_locked", locked, 1);
        chk("relock1_idx", phase_idx, 3);
        chk("relock1_rot", rot_cnt, 1);
        step(4'b1000);
        step(4'b0110);
        chk("badcode_err", err, 1);
        chk("badcode_locked", locked, 0);
        chk("badcode_errcnt", err_cnt, 2);
        // reverse rotation
        hp(4'b0001);
        hp(4'b0010);
        hp(4'b0100);
        hp(4'b1000);
        step(4'b0001);
        chk("relock2_locked", locked, 1);
        chk("relock2_rot", rot_cnt, 1);
        step(4'b0001);
        hp(4'b0010);
        chk("rev_pre_idx", phase_idx, 1);
        step(4'b0001);
        chk("rev_err", err, 1);
        chk("rev_locked", locked, 0);
        chk("rev_errcnt", err_cnt, 3);
        // early change during ACQ
        step(4'b0010);
        chk("early_acq_err", err, 0);
        step(4'b0100);
        chk("early_err", err, 1);
        chk("early_errcnt", err_cnt, 4);
        chk("early_locked", locked, 0);
        hp(4'b1000);
        hp(4'b0001);
        hp(4'b0010);
        hp(4'b0100);
        chk("early_prelock", locked, 0);
        step(4'b1000);
        chk("early_relock", locked, 1);
        chk("early_relock_idx", phase_idx, 3);
        step(4'b1000);
        step(4'b0001);
        chk("early_rot", rot_cnt, 2);
        // async reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_err", err, 0);
        chk("arst_errcnt", err_cnt, 0);
        chk("arst_rot", rot_cnt, 0);
        chk("arst_idx", phase_idx, 0);
        ph_in = 4'b0001;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_locked", locked, 0);
        step(4'b0001);
        hp(4'b0010);
        hp(4'b0100);
        hp(4'b1000);
        step(4'b0001);
        chk("rel_relock", locked, 1);
        chk("rel_rot", rot_cnt, 0);
        chk("rel_errcnt", err_cnt, 0);
        // err_cnt saturation
        step(4'b0000);
        chk("zero_err", err, 1);
        chk("zero_errcnt", err_cnt, 1);
        for (int i = 0; i < 254; i++) begin
            step(4'b0001);
            step(4'b0000);
        end
        chk("sat255", err_cnt, 255);
        for (int i = 0; i < 45; i++) begin
            step(4'b0001);
            step(4'b0000);
        end
        chk("sat_hold", err_cnt, 255);
        chk("sat_err", err, 1);
        // rotation counter wrap
        hp(4'b0001);
        hp(4'b0010);
        hp(4'b0100);
        hp(4'b1000);
        step(4'b0001);
        chk("wrap_lock", locked, 1);
        chk("wrap_start", rot_cnt, 0);
        step(4'b0001);
        for (int i = 0; i < 255; i++) begin
            hp(4'b0010);
            hp(4'b0100);
            hp(4'b1000);
            hp(4'b0001);
        end
        chk("wrap_255", rot_cnt, 255);
        chk("wrap_locked", locked, 1);
        hp(4'b0010);
        hp(4'b0100);
        hp(4'b1000);
        step(4'b0001);
        chk("wrap_0", rot_cnt, 0);
        chk("wrap_err", err, 0);
        chk("wrap_errcnt", err_cnt, 255);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/phase_ring_checker.md
Name: phase_ring_checker

Overview:
- Receive-side counterpart of the 4-output pulse divider; consumes its one-hot 4-phase bus q[3:0] (0001→0010→0100→1000→0001, each phase held HOLD clocks).
- Validates code, order and dwell time; acquires lock after LOCK_N consecutive good phase steps; reports current phase, completed rotations and error events.
- Sits on the same clk as the divider.
- Used as a self-checking monitor in divider benches and as a lock/health indicator in the top level.

Parameters:
- HOLD, 1, clocks each phase must stay active (≥1).
- LOCK_N, 4, consecutive good phase steps required to assert locked (≥1).
- CW, 8, width of rotation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset (0 = reset asserted).
- ph_in  in  4  phase bus from the divider.
- locked  out  1  lock indicator.
- phase_idx  out  2  index of active phase (0..3) while locked, else 0.
- rot_cnt  out  CW  completed rotations while locked, wraps.
- err  out  1  one-clock error pulse.
- err_cnt  out  8  error count, saturating at 255.

Behaviour:
- All state registered on rising clk.
- reset=0 clears immediately, independent of clk: cur=0000, dwell=0, good_cnt=0, state=IDLE, locked=0, phase_idx=0, rot_cnt=0, err=0, err_cnt=0.
- Each edge samples s=ph_in and compares it with cur, the previous sample. Outputs reflect sample s after that same edge (1-clock latency).
- dwell counts consecutive samples equal to cur. It is set to 1 on change and saturates at HOLD+1.
- Derived terms, evaluated on s, cur and dwell before update:
  - onehot = exactly one bit of s set.
  - change = (s != cur).
  - good_step = change && onehot && s == rotl(cur) && dwell == HOLD.
  - stall = !change && dwell == HOLD.
  - fault = !onehot || (change && !good_step) || stall.
- IDLE:
  - On change && onehot → ACQ, good_cnt=0.
  - All other samples stay in IDLE. No err in IDLE.
- ACQ:
  - On good_step: good_cnt++. When good_cnt+1 == LOCK_N → LOCK, locked=1 at that edge.
  - On fault → IDLE; err=1, err_cnt++.
- LOCK:
  - On good_step: phase_idx = index(s). If s==0001, rot_cnt++ (wraps at 2^CW).
  - On fault → IDLE; locked=0, phase_idx=0, err=1, err_cnt++. rot_cnt holds its value; it is not cleared on loss of lock.
- Fault handling:
  - A fault sample that is itself one-hot and a change re-enters ACQ from IDLE on the next qualifying change only, not on the same edge.
  - Only one err per edge, even if several fault terms are true.
- Boundaries:
  - ph_in=0000 or multi-hot → fault.
  - Reverse rotation (0010→0001) → fault.
  - Early change (dwell<HOLD) → fault.
  - Late change is caught as stall at the HOLD+1-th equal sample.
  - err_cnt holds at 255.
  - Reset mid-lock clears everything asynchronously. The first one-hot sample after release is a change from 0000 and starts ACQ.

Test Plan:
- Clean lock, HOLD=2, LOCK_N=4. Release reset, then drive 0001,0001,0010,0010,… starting edge k. Required: state ACQ after edge k; locked=1 after edge k+8; err never asserted; phase_idx follows 0,1,2,3; rot_cnt increments each time 0001 is re-entered while locked.
- Stall. Once locked, hold 0100 for 3 clocks. Required: at the 3rd equal sample, err=1 for exactly one clock; locked=0; err_cnt=1; rot_cnt unchanged.
- Bad code and order. While locked, inject 0110 → err pulse, unlock. Re-lock, then inject 0001 after 0010 (reverse) → err pulse, err_cnt=2.
- Early change. HOLD=2; change phase after 1 clock during ACQ. Required: err=1, return to IDLE, locked stays 0; relock after 4 further good steps.
- Async reset mid-lock. Assert reset=0 between clock edges. Required: locked, err, err_cnt, rot_cnt and phase_idx all zero immediately, without a clock edge. After release, normal re-acquisition.
- Saturation and wrap. Force 300 faults → err_cnt=255. Run 256 locked rotations with CW=8 → rot_cnt wraps to its start value.
